// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Initiator for an 8x32 (parameterisable) register file port. Accepts read or
// write burst commands, streams write beats straight onto the write port and
// returns read beats through a registered valid/ready response stream.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    // write-data stream
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // read-response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    // status
    output logic                  done,
    output logic                  busy,
    // register file write port
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [DATA_WIDTH-1:0] wData,
    output logic                  we,
    // register file read port
    output logic [ADDR_WIDTH-1:0] rAddr,
    input  logic [DATA_WIDTH-1:0] rData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic [ADDR_WIDTH-1:0]   rem_nxt;
    logic                    done_nxt;
    logic                    rsp_load;

    // Next-state, burst bookkeeping and handshake outputs.
    always_comb begin
        state_nxt = state;
        addr_nxt  = cur_addr;
        rem_nxt   = remaining;
        done_nxt  = 1'b0;
        rsp_load  = 1'b0;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rsp_valid = 1'b0;
        we        = 1'b0;
        wAddr     = cur_addr;
        wData     = wr_data;

        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_nxt  = cmd_addr;
                    rem_nxt   = cmd_len;
                    state_nxt = cmd_op ? S_WR : S_RD;
                end
            end
            S_WR: begin
                wr_ready = 1'b1;
                we       = wr_valid;
                if (wr_valid) begin
                    if (remaining == '0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        addr_nxt = cur_addr + ADDR_WIDTH'(1);
                        rem_nxt  = remaining - ADDR_WIDTH'(1);
                    end
                end
            end
            S_RD: begin
                rsp_load  = 1'b1;
                state_nxt = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (remaining == '0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        addr_nxt  = cur_addr + ADDR_WIDTH'(1);
                        rem_nxt   = remaining - ADDR_WIDTH'(1);
                        state_nxt = S_RD;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // State, address/count, done pulse and registered read path.
    // rAddr is loaded from the next address so it always tracks cur_addr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            rAddr     <= '0;
            done      <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= addr_nxt;
            remaining <= rem_nxt;
            rAddr     <= addr_nxt;
            done      <= done_nxt;
            if (rsp_load) begin
                rsp_data <= rData;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl
// Directed bench: a table of single-beat transactions plus hand-written burst,
// stall, back-pressure, latency, reset-abort and held-off command sequences.
// The bench owns the 8x32 register file the controller drives.
module tb_regfile_access_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [2:0]  cmd_addr;
    logic [2:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        done;
    logic        busy;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic        we;
    logic [2:0]  rAddr;
    logic [31:0] rData;

    int checks;
    int failures;

    logic [31:0] mem [8];

    regfile_access_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .done     (done),
        .busy     (busy),
        .wAddr    (wAddr),
        .wData    (wData),
        .we       (we),
        .rAddr    (rAddr),
        .rData    (rData)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: combinational read, write on the rising edge
    assign rData = mem[rAddr];
    always @(posedge clk) begin
        if (we) mem[wAddr] <= wData;
    end

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic send_cmd(input logic op, input logic [2:0] addr, input logic [2:0] len);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // One write beat, optionally preceded by stall cycles with wr_valid low.
    task automatic write_beat(input logic [2:0] exp_addr, input logic [31:0] data, input int stall);
        for (int i = 0; i < stall; i++) begin
            wr_valid = 1'b0;
            @(negedge clk);
            check("stall_we", {31'd0, we}, 32'd0);
            check("stall_wr_ready", {31'd0, wr_ready}, 32'd1);
            @(posedge clk); #1;
        end
        wr_valid = 1'b1;
        wr_data  = data;
        @(negedge clk);
        check("we", {31'd0, we}, 32'd1);
        check("wAddr", {29'd0, wAddr}, {29'd0, exp_addr});
        check("wData", wData, data);
        check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    // One read beat starting in the RD cycle, with optional back-pressure.
    task automatic read_beat(input logic [2:0] exp_addr, input logic [31:0] exp_data, input int stall);
        @(negedge clk);
        check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rAddr", {29'd0, rAddr}, {29'd0, exp_addr});
        check("rd_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rd_we", {31'd0, we}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < stall; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check("held_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("held_rsp_data", rsp_data, exp_data);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Done pulses for exactly one cycle after the final beat.
    task automatic finish_check();
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_clear", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        op;
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rsp_ready = 1'b0;

        // op=1 write data to addr; op=0 read addr expecting data
        vecs[0] = '{1'b1, 3'd0, 32'hA0A0_0001};
        vecs[1] = '{1'b1, 3'd3, 32'h1234_5678};
        vecs[2] = '{1'b0, 3'd0, 32'hA0A0_0001};
        vecs[3] = '{1'b0, 3'd3, 32'h1234_5678};
        vecs[4] = '{1'b1, 3'd3, 32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 3'd3, 32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 3'd5, 32'h0000_0000};
        vecs[7] = '{1'b0, 3'd5, 32'h0000_0000};

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rAddr", {29'd0, rAddr}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat table
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].op) begin
                send_cmd(1'b1, vecs[v].addr, 3'd0);
                write_beat(vecs[v].addr, vecs[v].data, 0);
                finish_check();
                check("tbl_mem", mem[vecs[v].addr], vecs[v].data);
            end else begin
                send_cmd(1'b0, vecs[v].addr, 3'd0);
                read_beat(vecs[v].addr, vecs[v].data, 0);
                finish_check();
            end
        end

        // T1: single write
        send_cmd(1'b1, 3'd2, 3'd0);
        write_beat(3'd2, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        check("t1_we_low", {31'd0, we}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_done_clear", {31'd0, done}, 32'd0);
        check("t1_mem", mem[2], 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // T2: wrapping write burst with a 2-cycle stall before beat 3
        send_cmd(1'b1, 3'd6, 3'd3);
        write_beat(3'd6, 32'd1, 0);
        write_beat(3'd7, 32'd2, 0);
        write_beat(3'd0, 32'd3, 2);
        write_beat(3'd1, 32'd4, 0);
        finish_check();
        check("t2_mem6", mem[6], 32'd1);
        check("t2_mem7", mem[7], 32'd2);
        check("t2_mem0", mem[0], 32'd3);
        check("t2_mem1", mem[1], 32'd4);

        // T3: wrapping read burst, beat 1 back-pressured 3 cycles
        send_cmd(1'b0, 3'd6, 3'd3);
        read_beat(3'd6, 32'd1, 3);
        read_beat(3'd7, 32'd2, 0);
        read_beat(3'd0, 32'd3, 0);
        read_beat(3'd1, 32'd4, 0);
        finish_check();

        // T4: single read latency (RD cycle then rsp_valid in the next)
        send_cmd(1'b0, 3'd2, 3'd0);
        read_beat(3'd2, 32'hDEAD_BEEF, 0);
        finish_check();

        // T5: reset during beat 2 of an 8-beat write
        send_cmd(1'b1, 3'd0, 3'd7);
        write_beat(3'd0, 32'h0000_0050, 0);
        wr_valid = 1'b1;
        wr_data  = 32'h0000_0052;
        @(negedge clk);
        check("t5_we_before", {31'd0, we}, 32'd1);
        check("t5_wAddr", {29'd0, wAddr}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_we_reset", {31'd0, we}, 32'd0);
        check("t5_busy_reset", {31'd0, busy}, 32'd0);
        check("t5_cmd_ready_reset", {31'd0, cmd_ready}, 32'd1);
        check("t5_wr_ready_reset", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_no_done", {31'd0, done}, 32'd0);
        check("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_no_done2", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        send_cmd(1'b0, 3'd0, 3'd1);
        read_beat(3'd0, 32'h0000_0050, 0);
        read_beat(3'd1, 32'd4, 0);
        finish_check();

        // T6: second command held high throughout a read burst
        send_cmd(1'b0, 3'd6, 3'd1);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_addr  = 3'd2;
        cmd_len   = 3'd0;
        read_beat(3'd6, 32'd1, 0);
        read_beat(3'd7, 32'd2, 0);
        @(negedge clk);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t6_busy", {31'd0, busy}, 32'd1);
        check("t6_rAddr", {29'd0, rAddr}, 32'd2);
        check("t6_done_clear", {31'd0, done}, 32'd0);
        check("t6_rd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t6_rsp_data", rsp_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        finish_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
